// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use bubble, EX stall hold, flush kill and stall watchdog
// Optional ID_EX_PERF_CNT_EN adds saturating bubble/flush event counters.
module id_ex_stage_reg #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int ALU_CTL_WIDTH = 4,
  parameter int STALL_LIMIT   = 255,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_dec_valid,
  input  logic [ADDR_WIDTH-1:0]    i_pc,
  input  logic [ALU_CTL_WIDTH-1:0] i_alu_ctl,
  input  logic                     i_uses_rw,
  input  logic [4:0]               i_rw_addr,
  input  logic                     i_is_mem_access,
  input  logic [DATA_WIDTH-1:0]    i_imm,
  input  logic [DATA_WIDTH-1:0]    i_rs_data,
  input  logic [DATA_WIDTH-1:0]    i_rt_data,
  input  logic                     i_lw_hazard,
  input  logic                     i_ex_stall,
  input  logic                     i_flush,
  output logic                     o_id_stall,
  output logic                     o_valid,
  output logic [ADDR_WIDTH-1:0]    o_pc,
  output logic [ALU_CTL_WIDTH-1:0] o_alu_ctl,
  output logic                     o_uses_rw,
  output logic [4:0]               o_rw_addr,
  output logic                     o_is_mem_access,
  output logic [DATA_WIDTH-1:0]    o_imm,
  output logic [DATA_WIDTH-1:0]    o_rs_data,
  output logic [DATA_WIDTH-1:0]    o_rt_data,
  output logic                     o_stall_timeout
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]     o_bubble_cnt,
  output logic [CNT_WIDTH-1:0]     o_flush_cnt
`endif
);

  localparam int SCW = $clog2(STALL_LIMIT + 1);
  localparam logic [SCW-1:0] LIMIT    = SCW'(STALL_LIMIT);
  localparam logic [SCW-1:0] LIMIT_M1 = SCW'(STALL_LIMIT - 1);

  if (STALL_LIMIT < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("id_ex_stage_reg: STALL_LIMIT and CNT_WIDTH must be >= 1");
  end

  logic           load_use;
  logic [SCW-1:0] stall_cnt;

  // A hazard only matters when decode actually holds an instruction.
  assign load_use   = i_lw_hazard & i_dec_valid;
  assign o_id_stall = ~rst & ~i_flush & (i_ex_stall | load_use);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid         <= 1'b0;
      o_pc            <= '0;
      o_alu_ctl       <= '0;
      o_uses_rw       <= 1'b0;
      o_rw_addr       <= '0;
      o_is_mem_access <= 1'b0;
      o_imm           <= '0;
      o_rs_data       <= '0;
      o_rt_data       <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_ex_stall) begin
      o_valid <= o_valid;
    end else if (load_use) begin
      o_valid <= 1'b0;
    end else begin
      o_valid         <= i_dec_valid;
      o_pc            <= i_pc;
      o_alu_ctl       <= i_alu_ctl;
      o_uses_rw       <= i_uses_rw;
      o_rw_addr       <= i_rw_addr;
      o_is_mem_access <= i_is_mem_access;
      o_imm           <= i_imm;
      o_rs_data       <= i_rs_data;
      o_rt_data       <= i_rt_data;
    end
  end

  // Watchdog: counts consecutive stalled cycles; timeout is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt       <= '0;
      o_stall_timeout <= 1'b0;
    end else if (o_id_stall) begin
      if (stall_cnt != LIMIT) stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt >= LIMIT_M1) o_stall_timeout <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_bubble_cnt <= '0;
      o_flush_cnt  <= '0;
    end else begin
      if (~i_flush & ~i_ex_stall & load_use & ~&o_bubble_cnt)
        o_bubble_cnt <= o_bubble_cnt + 1'b1;
      if (i_flush & ~&o_flush_cnt)
        o_flush_cnt <= o_flush_cnt + 1'b1;
    end
  end
`endif

endmodule
